// File: rtl/sample_ram_responder.sv
// sample_ram_responder: on-chip block-RAM stand-in for the recorder's DDR
// interface. It uses the same rdy / write / read-request / data-present /
// ack handshake as the DDR interface, so the record/playback FSM can run
// unchanged against local storage.
module sample_ram_responder #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 26,
  parameter int DEPTH_LOG2   = 14,
  parameter int READ_LATENCY = 2,
  parameter int WRITE_BUSY   = 1
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_en,
  input  logic                  read_req,
  input  logic                  read_ack,
  output logic [DATA_WIDTH-1:0] read_out,
  output logic                  data_present,
  output logic                  rdy,
  output logic [ADDR_WIDTH-1:0] max_ram_address,
  output logic                  addr_error
);

  // The counter must hold READ_LATENCY-1 and WRITE_BUSY-1.
  localparam int CNT_MAX = (READ_LATENCY > WRITE_BUSY) ? READ_LATENCY : WRITE_BUSY;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'((WRITE_BUSY > 0) ? WRITE_BUSY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    WR_BUSY,
    RD_WAIT,
    RD_VALID
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_n;
  logic                    rdy_n;
  logic                    present_n;
  logic [DATA_WIDTH-1:0]   read_out_n;
  logic                    err_n;
  logic [DEPTH_LOG2-1:0]   rd_addr;
  logic [DEPTH_LOG2-1:0]   rd_addr_n;
  logic                    rd_oor;
  logic                    rd_oor_n;
  logic                    mem_we;
  logic                    addr_oor;
  logic [DEPTH_LOG2-1:0]   mem_addr_in;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_q;
  logic [DATA_WIDTH-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

  // Any non-zero bit above the array index means the address is beyond the array.
  assign addr_oor        = |addr_in[ADDR_WIDTH-1:DEPTH_LOG2];
  assign mem_addr_in     = addr_in[DEPTH_LOG2-1:0];
  assign max_ram_address = {{(ADDR_WIDTH-DEPTH_LOG2){1'b0}}, {DEPTH_LOG2{1'b1}}};

  // While idle, the RAM reads from the live address, so a latency of one still
  // has the data ready. After that, it reads from the address latched at acceptance.
  assign ram_addr = (state == IDLE) ? mem_addr_in : rd_addr;

  // Block-RAM array: no reset, so contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr_in] <= data_in;
    end
    ram_q <= mem[ram_addr];
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      cnt          <= '0;
      rdy          <= 1'b0;
      data_present <= 1'b0;
      read_out     <= '0;
      addr_error   <= 1'b0;
      rd_addr      <= '0;
      rd_oor       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      rdy          <= rdy_n;
      data_present <= present_n;
      read_out     <= read_out_n;
      addr_error   <= err_n;
      rd_addr      <= rd_addr_n;
      rd_oor       <= rd_oor_n;
    end
  end

  // Next-state and next-output decode. While in IDLE with rdy low, the block
  // spends one recovery cycle. This covers both the first cycle after reset
  // and the tail of every write.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rdy_n      = rdy;
    present_n  = data_present;
    read_out_n = read_out;
    err_n      = addr_error;
    rd_addr_n  = rd_addr;
    rd_oor_n   = rd_oor;
    mem_we     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rdy) begin
          rdy_n = 1'b1;
        end else if (write_en) begin
          mem_we = !addr_oor;
          if (addr_oor) begin
            err_n = 1'b1;
          end
          rdy_n = 1'b0;
          if (WRITE_BUSY > 0) begin
            state_n = WR_BUSY;
            cnt_n   = WR_LOAD;
          end
        end else if (read_req) begin
          if (addr_oor) begin
            err_n = 1'b1;
          end
          rdy_n     = 1'b0;
          rd_addr_n = mem_addr_in;
          rd_oor_n  = addr_oor;
          cnt_n     = RD_LOAD;
          state_n   = RD_WAIT;
        end
      end
      WR_BUSY: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          read_out_n = rd_oor ? '0 : ram_q;
          present_n  = 1'b1;
          state_n    = RD_VALID;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RD_VALID: begin
        if (read_ack) begin
          present_n = 1'b0;
          rdy_n     = 1'b1;
          state_n   = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sample_ram_responder.sv
// Scoreboard bench for sample_ram_responder: a driver issues commands and
// queues the expected read data; a monitor pops and checks each read response.
module tb_sample_ram_responder;

  localparam int DW    = 16;
  localparam int AW    = 26;
  localparam int DL2   = 14;
  localparam int RDLAT = 2;
  localparam int WRB   = 1;
  localparam int DEPTH = 1 << DL2;
  localparam logic [AW-1:0] MAX_ADDR = AW'(DEPTH - 1);

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          write_en = 1'b0;
  logic          read_req = 1'b0;
  logic          read_ack = 1'b0;
  logic [DW-1:0] read_out;
  logic          data_present;
  logic          rdy;
  logic [AW-1:0] max_ram_address;
  logic          addr_error;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_mem [0:DEPTH-1];
  logic          err_model = 1'b0;
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] written_q [$];
  logic          dp_seen = 1'b0;

  sample_ram_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL2),
    .READ_LATENCY(RDLAT), .WRITE_BUSY(WRB)
  ) dut (
    .clk(clk), .RST(RST), .addr_in(addr_in), .data_in(data_in),
    .write_en(write_en), .read_req(read_req), .read_ack(read_ack),
    .read_out(read_out), .data_present(data_present), .rdy(rdy),
    .max_ram_address(max_ram_address), .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a > MAX_ADDR) return '0;
    return model_mem[a[DL2-1:0]];
  endfunction

  // Monitor: every rising data_present must match the oldest expected read.
  always @(negedge clk) begin
    logic [DW-1:0] exp;
    if (data_present && !dp_seen) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL spurious_present: got data_present=1 expected 0");
      end else begin
        exp = exp_q.pop_front();
        check_output("read_data", 32'(read_out), 32'(exp));
      end
    end
    dp_seen = data_present;
  end

  task automatic apply_stimulus(input logic we, input logic re, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) check_output("rdy_timeout", 32'(rdy), 32'd1);
    write_en = we;
    read_req = re;
    addr_in  = a;
    data_in  = d;
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0;
    read_req = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic also_read);
    int low = 0;
    apply_stimulus(1'b1, also_read, a, d);
    if (a > MAX_ADDR) begin
      err_model = 1'b1;
    end else begin
      model_mem[a[DL2-1:0]] = d;
      written_q.push_back(a);
    end
    while (!rdy && low < 20) begin
      low++;
      @(negedge clk);
    end
    check_output("write_busy_cycles", 32'(low), 32'(1 + WRB));
    check_output("addr_error", 32'(addr_error), 32'(err_model));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold);
    int lat = 0;
    int lost = 0;
    apply_stimulus(1'b0, 1'b1, a, '0);
    exp_q.push_back(model_read(a));
    if (a > MAX_ADDR) err_model = 1'b1;
    while (!data_present && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_output("read_latency", 32'(lat), 32'(RDLAT));
    repeat (hold) begin
      @(negedge clk);
      if (!data_present || rdy) lost++;
    end
    check_output("present_hold", 32'(lost), 32'd0);
    read_ack = 1'b1;
    @(negedge clk);
    read_ack = 1'b0;
    check_output("ack_clears_present", 32'(data_present), 32'd0);
    check_output("ack_rdy", 32'(rdy), 32'd1);
    check_output("addr_error", 32'(addr_error), 32'(err_model));
  endtask

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [AW-1:0] last_addr;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("reset_rdy", 32'(rdy), 32'd0);
    check_output("reset_present", 32'(data_present), 32'd0);
    check_output("reset_read_out", 32'(read_out), 32'd0);
    check_output("max_ram_address", 32'(max_ram_address), 32'h0003FFF);
    check_output("reset_addr_error", 32'(addr_error), 32'd0);
    RST = 1'b1;
    @(negedge clk);
    check_output("rdy_after_reset", 32'(rdy), 32'd1);

    // Single write, then a read held for ten cycles before ack
    do_write(26'd5, 16'hA5C3, 1'b0);
    do_read(26'd5, 10);

    // Write and read together: the write wins and no read response appears
    do_write(26'd7, 16'h1234, 1'b1);
    repeat (5) @(negedge clk);
    do_read(26'd7, 1);

    // Record sixteen samples, then play them back
    for (int i = 0; i < 16; i++) do_write(AW'(i), DW'(i * 3), 1'b0);
    for (int i = 0; i < 16; i++) do_read(AW'(i), i % 3);

    // Top address followed by the wrap to zero
    do_write(MAX_ADDR, 16'hBEEF, 1'b0);
    do_write(26'd0, 16'h0F0F, 1'b0);
    do_read(MAX_ADDR, 0);
    do_read(26'd0, 0);

    // Out-of-range write is dropped and sets the sticky error flag
    do_write(26'h0004000, 16'hFFFF, 1'b0);
    check_output("oor_error_set", 32'(addr_error), 32'd1);
    do_read(26'd0, 2);
    do_read(26'h0004000, 2);
    check_output("oor_error_sticky", 32'(addr_error), 32'd1);

    // Randomized mix of in-range and out-of-range commands
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) < 2) begin
        if ($urandom_range(0, 7) == 0)
          a = {12'($urandom_range(1, 4095)), 14'($urandom_range(0, DEPTH - 1))};
        else
          a = AW'($urandom_range(0, DEPTH - 1));
        d = DW'($urandom);
        do_write(a, d, 1'b0);
      end else begin
        if ($urandom_range(0, 7) == 0)
          a = {12'($urandom_range(1, 4095)), 14'($urandom_range(0, DEPTH - 1))};
        else
          a = written_q[$urandom_range(0, written_q.size() - 1)];
        do_read(a, $urandom_range(0, 4));
      end
    end

    // Reset while a read is waiting on the RAM
    last_addr = 26'd5;
    apply_stimulus(1'b0, 1'b1, last_addr, '0);
    #2;
    RST = 1'b0;
    #1;
    check_output("midread_reset_present", 32'(data_present), 32'd0);
    err_model = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (data_present) check_output("reset_hold_present", 32'(data_present), 32'd0);
    end
    check_output("reset_hold_rdy", 32'(rdy), 32'd0);
    RST = 1'b1;
    @(negedge clk);
    check_output("rdy_after_midread_reset", 32'(rdy), 32'd1);
    check_output("addr_error_cleared", 32'(addr_error), 32'd0);
    do_read(last_addr, 1);

    repeat (3) @(negedge clk);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
